spi_fifo: RTL
=============

Name: spi_fifo

Overview:
- Parametrised synchronous FIFO for the SPI TX/RX data paths; wraps a dual-port RAM with pointer, occupancy and status logic.
- Adds full/empty, programmable almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a registered read port with a data-valid strobe.
- Sits between the bus-side register interface and the SPI shift engine, one instance per direction.

Parameters:
- DATAWIDTH, 8, width of each data word.
- DATADEPTH, 16, number of entries; must be a power of 2, at least 2.
- ADDRESSWIDTH, $clog2(DATADEPTH), RAM address width; derived, never overridden.
- ALMOSTFULL, DATADEPTH-2, almostFull asserts when count >= ALMOSTFULL.
- ALMOSTEMPTY, 2, almostEmpty asserts when count <= ALMOSTEMPTY.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush.
- writeEn  input  1  write request.
- dataIn  input  DATAWIDTH  write data.
- readEn  input  1  read request.
- dataOut  output  DATAWIDTH  registered read data.
- dataValid  output  1  dataOut holds a newly read word this cycle.
- full  output  1  count == DATADEPTH.
- empty  output  1  count == 0.
- almostFull  output  1  count >= ALMOSTFULL.
- almostEmpty  output  1  count <= ALMOSTEMPTY.
- count  output  ADDRESSWIDTH+1  current occupancy, 0..DATADEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset low, asynchronous): pointers = 0, count = 0, dataOut = 0, dataValid = 0, overflow = 0, underflow = 0. Therefore empty = 1, almostEmpty = 1, full = 0, almostFull = 0. RAM contents are not reset.
- Reset deasserted mid-operation: the FIFO comes back empty; words in flight are discarded.
- Pointers are ADDRESSWIDTH+1 bits. The low ADDRESSWIDTH bits address the RAM. Both pointers wrap naturally modulo 2*DATADEPTH.
- Write accepted iff writeEn && !full. The word is stored at wrPtr and wrPtr increments.
- Full is judged on the current registered state. A write while full is rejected even if a read is accepted in the same cycle.
- Read accepted iff readEn && !empty. rdPtr increments.
  - dataOut takes mem[rdPtr] on that edge, so the word is visible in the next cycle.
  - dataValid is high for exactly that one cycle.
  - On a non-accepted cycle dataValid = 0 and dataOut holds its last value.
- Read latency: 1 cycle from the readEn edge to dataOut/dataValid.
- Write-to-read latency: a word written at edge N can be read at edge N+1, because empty deasserts after edge N.
- count update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous read and write with 0 < count < DATADEPTH: both proceed and count is unchanged.
- Read and write while empty: the write is accepted, the read is rejected and underflow is set.
- Status flags are combinational decodes of the registered count and are glitch-free relative to clk.
- overflow is set on writeEn && full; underflow is set on readEn && empty. Both stay set until clear or reset.
- clear: on the edge it is sampled high, pointers, count, overflow, underflow and dataValid go to 0. Any writeEn/readEn in that cycle is ignored, and no flag is set by it. dataOut holds its value.

Decomposition:
- Package spi_fifo_pkg: the power-of-2 depth check as a function used in an elaboration-time assertion, and the default DATAWIDTH/DATADEPTH constants shared by the TX and RX instances.
- Sub-module spi_fifo_ram: simple dual-port RAM with one write port and one registered read port, parametrised DATAWIDTH/DATADEPTH. Its read-enable gates the output register so dataOut holds when no read occurs.
- spi_fifo holds pointers, count, flags and control only.

Test Plan (DATAWIDTH=8, DATADEPTH=16, ALMOSTFULL=14, ALMOSTEMPTY=2):
- Reset, then idle -> empty=1, almostEmpty=1, full=0, count=0, dataValid=0, dataOut=8'h00.
- Write 8'h01..8'h10 on 16 consecutive cycles -> count 1..16; almostEmpty drops after the 3rd write; almostFull rises after the 14th; full=1 after the 16th. Then one read per cycle -> dataOut 8'h01..8'h10, each one cycle after readEn with dataValid=1, and empty=1 at the end.
- With the FIFO full, assert writeEn and readEn together with dataIn=8'hAA -> write rejected, overflow=1, count=15. 8'hAA never appears on reads.
- Fill 10 words, then drain with concurrent writes for 40 cycles (pointers wrap twice) -> count stays 10 and the read data sequence exactly matches the write order.
- With the FIFO empty, assert readEn -> underflow=1 and dataValid stays 0. Then assert clear together with writeEn -> count=0, overflow=0, underflow=0, and the write is discarded.
- Write 5 words, assert reset low asynchronously mid-cycle -> empty=1 immediately, without waiting for a clock edge. After release, write 8'h5A and read -> dataOut=8'h5A.

Source files
------------

// File: rtl/spi_fifo_pkg.sv
// Shared constants and elaboration helpers for the SPI TX/RX FIFOs.
package spi_fifo_pkg;
    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_DATADEPTH = 16;

    // Depth must be a power of two so the extra pointer bit wraps cleanly.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction
endpackage

// File: rtl/spi_fifo_if.sv
// Bus-side / engine-side handshake bundle for one SPI FIFO instance.
interface spi_fifo_if
    import spi_fifo_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int DATADEPTH = DEF_DATADEPTH
) ();
    localparam int ADDRESSWIDTH = $clog2(DATADEPTH);

    logic                  clear;
    logic                  writeEn;
    logic [DATAWIDTH-1:0]  dataIn;
    logic                  readEn;
    logic [DATAWIDTH-1:0]  dataOut;
    logic                  dataValid;
    logic                  full;
    logic                  empty;
    logic                  almostFull;
    logic                  almostEmpty;
    logic [ADDRESSWIDTH:0] count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, writeEn, dataIn, readEn,
        input  dataOut, dataValid, full, empty, almostFull, almostEmpty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, writeEn, dataIn, readEn,
        output dataOut, dataValid, full, empty, almostFull, almostEmpty,
               count, overflow, underflow
    );
endinterface

// File: rtl/spi_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when idle.
module spi_fifo_ram
    import spi_fifo_pkg::*;
#(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int DATADEPTH    = DEF_DATADEPTH,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we_i,
    input  logic [ADDRESSWIDTH-1:0] waddr_i,
    input  logic [DATAWIDTH-1:0]    wdata_i,
    input  logic                    re_i,
    input  logic [ADDRESSWIDTH-1:0] raddr_i,
    output logic [DATAWIDTH-1:0]    rdata_o
);
    logic [DATAWIDTH-1:0] mem_q [DATADEPTH];
    logic [DATAWIDTH-1:0] rdata_q;

    // Storage array; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Output register only loads on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/spi_fifo.sv
// Synchronous FIFO for SPI data paths: pointers, occupancy, status and sticky errors.
module spi_fifo
    import spi_fifo_pkg::*;
#(
    parameter int DATAWIDTH   = DEF_DATAWIDTH,
    parameter int DATADEPTH   = DEF_DATADEPTH,
    parameter int ALMOSTFULL  = DATADEPTH - 2,
    parameter int ALMOSTEMPTY = 2
) (
    input  logic clk,
    input  logic reset,
    spi_fifo_if.slave bus
);
    localparam int ADDRESSWIDTH = $clog2(DATADEPTH);
    localparam logic [ADDRESSWIDTH:0] DEPTH_C = (ADDRESSWIDTH+1)'(DATADEPTH);
    localparam logic [ADDRESSWIDTH:0] AF_C    = (ADDRESSWIDTH+1)'(ALMOSTFULL);
    localparam logic [ADDRESSWIDTH:0] AE_C    = (ADDRESSWIDTH+1)'(ALMOSTEMPTY);

    if (!is_pow2(DATADEPTH)) begin : g_depth_chk
        $error("spi_fifo: DATADEPTH must be a power of 2 and at least 2");
    end

    logic [ADDRESSWIDTH:0] wrPtr_q, wrPtr_d;
    logic [ADDRESSWIDTH:0] rdPtr_q, rdPtr_d;
    logic [ADDRESSWIDTH:0] count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  vld_q, vld_d;
    logic                  full, empty, wr_acc, rd_acc;

    // Flags decode the registered count only, so they never glitch mid-cycle.
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    // Clear wins over any request in the same cycle.
    assign wr_acc = bus.writeEn && !full  && !bus.clear;
    assign rd_acc = bus.readEn  && !empty && !bus.clear;

    // Next-state for pointers, occupancy and sticky errors.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        vld_d   = rd_acc;
        if (bus.clear) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            vld_d   = 1'b0;
        end else begin
            if (wr_acc) wrPtr_d = wrPtr_q + 1'b1;
            if (rd_acc) rdPtr_d = rdPtr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (bus.writeEn && full)  ovf_d = 1'b1;
            if (bus.readEn  && empty) udf_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            vld_q   <= vld_d;
        end
    end

    spi_fifo_ram #(
        .DATAWIDTH   (DATAWIDTH),
        .DATADEPTH   (DATADEPTH),
        .ADDRESSWIDTH(ADDRESSWIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we_i   (wr_acc),
        .waddr_i(wrPtr_q[ADDRESSWIDTH-1:0]),
        .wdata_i(bus.dataIn),
        .re_i   (rd_acc),
        .raddr_i(rdPtr_q[ADDRESSWIDTH-1:0]),
        .rdata_o(bus.dataOut)
    );

    assign bus.dataValid   = vld_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostFull  = (count_q >= AF_C);
    assign bus.almostEmpty = (count_q <= AE_C);
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
endmodule
